piso_serializer: RTL

- Parallel-in, serial-out stage directly upstream of the 4-bit serial shift-register delay line.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on ser_out, which drives the shift register's serial input.
- A one-word holding buffer gives gap-free back-to-back frames.

---
 rtl/serdes_pkg.sv | 16 +
 rtl/piso_serializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serdes_pkg.sv
// Shared types and sizing helpers for the serializer/deserializer blocks.
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter only needs to reach WIDTH-1 (bits still to emit after the first).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with a one-word holding buffer; emits one bit
// per enabled clock on ser_out, back-to-back words without bubbles.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;

  logic             accept;
  logic             load_word;
  logic             bypass;
  logic [WIDTH-1:0] word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign accept = load_valid & ~buf_full_q;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    load_word     = 1'b0;
    bypass        = 1'b0;
    word          = '0;

    if (shift_en) begin
      // IDLE always sits with cnt=0, so both cases reduce to a frame boundary.
      if (state_q == IDLE || cnt_q == '0) begin
        if (buf_full_q) begin
          load_word  = 1'b1;
          word       = buf_q;
          buf_full_d = 1'b0;
        end else if (accept) begin
          load_word = 1'b1;
          bypass    = 1'b1;
          word      = load_data;
        end else begin
          state_d       = IDLE;
          ser_out_d     = 1'b0;
          ser_valid_d   = 1'b0;
          frame_start_d = 1'b0;
        end
      end else begin
        ser_out_d     = first_bit(shreg_q);
        shreg_d       = advance(shreg_q);
        cnt_d         = cnt_q - CNT_ONE;
        frame_start_d = 1'b0;
      end
    end

    if (load_word) begin
      state_d       = SHIFT;
      ser_out_d     = first_bit(word);
      shreg_d       = advance(word);
      cnt_d         = CNT_LOAD;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end

    if (accept && !bypass) begin
      buf_d      = load_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
    end
  end

  assign load_ready  = ~buf_full_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == SHIFT) | buf_full_q;

endmodule
